// File: rtl/rdoq_pkg.sv
// Shared widths, cost type and saturating cost arithmetic for the RDOQ cost/selection path.
package rdoq_pkg;

    localparam int DIST_WIDTH   = 162;
    localparam int LEVEL_WIDTH  = 32;
    localparam int RATE_WIDTH   = 24;
    localparam int LAMBDA_WIDTH = 32;
    localparam int COST_WIDTH   = 164;
    localparam int PROD_WIDTH   = RATE_WIDTH + LAMBDA_WIDTH;

    typedef logic [COST_WIDTH-1:0]  cost_t;
    typedef logic [LEVEL_WIDTH-1:0] level_t;
    typedef logic [PROD_WIDTH-1:0]  prod_t;

    localparam cost_t COST_MAX = '1;

    // Winner held by the running-best stage and handed to the output stage.
    typedef struct packed {
        level_t level;
        cost_t  cost;
    } cand_result_t;

    function automatic cost_t sat_add(input cost_t a, input cost_t b);
        logic [COST_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COST_WIDTH] ? COST_MAX : sum[COST_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rdoq_cost_calc.sv
// Two-stage cost pipeline: S1 registers (lambda*rate)>>LAMBDA_SHIFT, S2 registers the saturated D + product.
module rdoq_cost_calc
    import rdoq_pkg::*;
#(
    parameter int LAMBDA_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [DIST_WIDTH-1:0]   dist_i,
    input  logic [LEVEL_WIDTH-1:0]  level_i,
    input  logic [RATE_WIDTH-1:0]   rate_i,
    input  logic                    last_i,
    input  logic [LAMBDA_WIDTH-1:0] lambda_i,
    output logic                    valid_o,
    output cost_t                   cost_o,
    output level_t                  level_o,
    output logic                    last_o
);

    prod_t                   prod_d;
    prod_t                   s1_prod_q;
    logic [DIST_WIDTH-1:0]   s1_dist_q;
    level_t                  s1_level_q;
    logic                    s1_last_q;
    logic                    s1_valid_q;

    assign prod_d = (PROD_WIDTH'(lambda_i) * PROD_WIDTH'(rate_i)) >> LAMBDA_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            s1_valid_q <= valid_i;
            valid_o    <= s1_valid_q;
        end
    end

    // NOTE: only the valid bits are reset; payload registers are qualified by valid, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        s1_prod_q  <= prod_d;
        s1_dist_q  <= dist_i;
        s1_level_q <= level_i;
        s1_last_q  <= last_i;
        cost_o     <= sat_add(cost_t'(s1_dist_q), cost_t'(s1_prod_q));
        level_o    <= s1_level_q;
        last_o     <= s1_last_q;
    end

endmodule

// File: rtl/rdoq_cost_select.sv
// RDOQ level selection: per coefficient, picks the minimum RD-cost candidate (ties -> smaller level)
// and emits it with a wrapping coefficient index; block_done_out marks the last coefficient of a block.
module rdoq_cost_select
    import rdoq_pkg::*;
#(
    parameter int  NUM_COEFF    = 16,
    parameter int  LAMBDA_SHIFT = 0,
    localparam int IDX_WIDTH    = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_valid_in,
    input  logic [DIST_WIDTH-1:0]   distortion_in,
    input  logic [LEVEL_WIDTH-1:0]  cand_level_in,
    input  logic [RATE_WIDTH-1:0]   cand_rate_in,
    input  logic                    cand_last_in,
    input  logic [LAMBDA_WIDTH-1:0] lambda_in,
    output logic                    best_valid_out,
    output logic [LEVEL_WIDTH-1:0]  best_level_out,
    output logic [COST_WIDTH-1:0]   best_cost_out,
    output logic [IDX_WIDTH-1:0]    coef_idx_out,
    output logic                    block_done_out
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COEFF - 1);

    logic         s2_valid;
    cost_t        s2_cost;
    level_t       s2_level;
    logic         s2_last;

    logic         first_pending_q;
    cand_result_t best_q;
    cand_result_t win_d;
    cand_result_t res_q;
    logic         res_valid_q;
    logic [IDX_WIDTH-1:0] idx_q;

    rdoq_cost_calc #(
        .LAMBDA_SHIFT (LAMBDA_SHIFT)
    ) u_cost_calc (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (data_valid_in),
        .dist_i   (distortion_in),
        .level_i  (cand_level_in),
        .rate_i   (cand_rate_in),
        .last_i   (cand_last_in),
        .lambda_i (lambda_in),
        .valid_o  (s2_valid),
        .cost_o   (s2_cost),
        .level_o  (s2_level),
        .last_o   (s2_last)
    );

    // The first candidate of a group wins unconditionally, so a stale best never leaks across groups.
    always_comb begin
        win_d = best_q;
        if (first_pending_q || (s2_cost < best_q.cost) ||
            ((s2_cost == best_q.cost) && (s2_level < best_q.level))) begin
            win_d.level = s2_level;
            win_d.cost  = s2_cost;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_pending_q <= 1'b1;
            best_q          <= '0;
            res_q           <= '0;
            res_valid_q     <= 1'b0;
        end else begin
            res_valid_q <= s2_valid && s2_last;
            if (s2_valid) begin
                best_q          <= win_d;
                first_pending_q <= s2_last;
                if (s2_last) begin
                    res_q <= win_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_valid_out <= 1'b0;
            best_level_out <= '0;
            best_cost_out  <= '0;
            coef_idx_out   <= '0;
            block_done_out <= 1'b0;
            idx_q          <= '0;
        end else begin
            best_valid_out <= res_valid_q;
            block_done_out <= res_valid_q && (idx_q == LAST_IDX);
            if (res_valid_q) begin
                best_level_out <= res_q.level;
                best_cost_out  <= res_q.cost;
                coef_idx_out   <= idx_q;
                idx_q          <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rdoq_cost_select.sv
// Scoreboard bench for rdoq_cost_select: each group pushes its expected result, a negedge monitor pops and compares.
module tb_rdoq_cost_select;
    import rdoq_pkg::*;

    localparam int NC   = 4;
    localparam int IDXW = 2;

    typedef struct {
        logic [DIST_WIDTH-1:0]  d;
        logic [LEVEL_WIDTH-1:0] lvl;
        logic [RATE_WIDTH-1:0]  r;
    } cand_t;

    typedef struct {
        logic [LEVEL_WIDTH-1:0] lvl;
        logic [COST_WIDTH-1:0]  cost;
        logic [IDXW-1:0]        idx;
        logic                   done;
        int                     cyc;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    data_valid_in = 1'b0;
    logic [DIST_WIDTH-1:0]   distortion_in = '0;
    logic [LEVEL_WIDTH-1:0]  cand_level_in = '0;
    logic [RATE_WIDTH-1:0]   cand_rate_in = '0;
    logic                    cand_last_in = 1'b0;
    logic [LAMBDA_WIDTH-1:0] lambda_in = '0;
    logic                    best_valid_out;
    logic [LEVEL_WIDTH-1:0]  best_level_out;
    logic [COST_WIDTH-1:0]   best_cost_out;
    logic [IDXW-1:0]         coef_idx_out;
    logic                    block_done_out;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   exp_idx = 0;
    logic mon_en  = 1'b0;

    rdoq_cost_select #(
        .NUM_COEFF    (NC),
        .LAMBDA_SHIFT (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_valid_in  (data_valid_in),
        .distortion_in  (distortion_in),
        .cand_level_in  (cand_level_in),
        .cand_rate_in   (cand_rate_in),
        .cand_last_in   (cand_last_in),
        .lambda_in      (lambda_in),
        .best_valid_out (best_valid_out),
        .best_level_out (best_level_out),
        .best_cost_out  (best_cost_out),
        .coef_idx_out   (coef_idx_out),
        .block_done_out (block_done_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    function automatic cand_t mk(input logic [DIST_WIDTH-1:0] d, input int lvl, input int r);
        cand_t c;
        c.d   = d;
        c.lvl = LEVEL_WIDTH'(lvl);
        c.r   = RATE_WIDTH'(r);
        return c;
    endfunction

    // Reference cost: exact D + lambda*R, clamped to all-ones on overflow of COST_WIDTH.
    function automatic logic [COST_WIDTH-1:0] model_cost(input cand_t c, input logic [LAMBDA_WIDTH-1:0] lam);
        logic [COST_WIDTH+1:0] exact;
        exact = (COST_WIDTH+2)'(c.d) + (COST_WIDTH+2)'(lam) * (COST_WIDTH+2)'(c.r);
        if (exact > (COST_WIDTH+2)'({COST_WIDTH{1'b1}}))
            return {COST_WIDTH{1'b1}};
        return exact[COST_WIDTH-1:0];
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (best_valid_out) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got level=%0d idx=%0d at cyc %0d, required no pulse",
                             best_level_out, coef_idx_out, cyc);
                end else begin
                    e = sb.pop_front();
                    if (best_level_out !== e.lvl) begin
                        n_fail++;
                        $display("FAIL level: got %0d, required %0d", best_level_out, e.lvl);
                    end
                    n_tests++;
                    if (best_cost_out !== e.cost) begin
                        n_fail++;
                        $display("FAIL cost: got %0h, required %0h", best_cost_out, e.cost);
                    end
                    n_tests++;
                    if (coef_idx_out !== e.idx) begin
                        n_fail++;
                        $display("FAIL coef_idx: got %0d, required %0d", coef_idx_out, e.idx);
                    end
                    n_tests++;
                    if (block_done_out !== e.done) begin
                        n_fail++;
                        $display("FAIL block_done: got %0b, required %0b", block_done_out, e.done);
                    end
                    n_tests++;
                    if (cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL latency: pulse at cyc %0d, required cyc %0d", cyc, e.cyc);
                    end
                end
            end else if (block_done_out) begin
                n_tests++;
                n_fail++;
                $display("FAIL block_done_alone: got 1 without best_valid, required 0");
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        data_valid_in = 1'b0;
        cand_last_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_idx = 0;
        mon_en = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        data_valid_in = 1'b0;
        cand_last_in  = 1'b0;
    endtask

    // Drives one group (gap idle cycles between candidates) and pushes its expected result.
    task automatic send_group(input cand_t g[$], input logic [LAMBDA_WIDTH-1:0] lam, input int gap);
        exp_t                   e;
        logic [COST_WIDTH-1:0]  bc;
        logic [LEVEL_WIDTH-1:0] bl;
        logic [COST_WIDTH-1:0]  c;
        bc = '0;
        bl = '0;
        for (int i = 0; i < g.size(); i++) begin
            c = model_cost(g[i], lam);
            if (i == 0 || c < bc || (c == bc && g[i].lvl < bl)) begin
                bc = c;
                bl = g[i].lvl;
            end
        end
        for (int i = 0; i < g.size(); i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    data_valid_in = 1'b0;
                    distortion_in = '0;
                    cand_level_in = '0;
                    cand_rate_in  = '0;
                    cand_last_in  = 1'b1;
                end
            end
            @(negedge clk);
            data_valid_in = 1'b1;
            distortion_in = g[i].d;
            cand_level_in = g[i].lvl;
            cand_rate_in  = g[i].r;
            cand_last_in  = (i == g.size() - 1);
            lambda_in     = lam;
            if (i == g.size() - 1) begin
                e.lvl  = bl;
                e.cost = bc;
                e.idx  = IDXW'(exp_idx);
                e.done = (exp_idx == NC - 1);
                e.cyc  = cyc + 4;
                sb.push_back(e);
                exp_idx = (exp_idx + 1) % NC;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test1_group(input int gap);
        cand_t g[$];
        g.push_back(mk(DIST_WIDTH'(12544), 2, 8));
        g.push_back(mk(DIST_WIDTH'(10000), 1, 4));
        g.push_back(mk(DIST_WIDTH'(65536), 0, 1));
        send_group(g, 32'd16, gap);
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if (best_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", best_valid_out); end
        n_tests++;
        if (best_level_out !== '0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", best_level_out); end
        n_tests++;
        if (best_cost_out !== '0) begin n_fail++; $display("FAIL reset_cost: got %0h, required 0", best_cost_out); end
        n_tests++;
        if (coef_idx_out !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d, required 0", coef_idx_out); end
        n_tests++;
        if (block_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b, required 0", block_done_out); end
    endtask

    task automatic test_single_group();
        test1_group(0);
        wait_drain();
        n_tests++;
        if (best_level_out !== 32'd1 || best_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got level=%0d valid=%0b, required level=1 valid=0", best_level_out, best_valid_out);
        end
    endtask

    task automatic test_reset_mid_group();
        cand_t g[$];
        g.push_back(mk(DIST_WIDTH'(1), 7, 0));
        g.push_back(mk(DIST_WIDTH'(1), 6, 0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data_valid_in = 1'b1;
            distortion_in = g[i].d;
            cand_level_in = g[i].lvl;
            cand_rate_in  = g[i].r;
            cand_last_in  = 1'b0;
            lambda_in     = 32'd16;
        end
        do_reset();
        test1_group(0);
        wait_drain();
    endtask

    task automatic test_tie();
        cand_t g[$];
        g.push_back(mk(DIST_WIDTH'(490), 3, 10));
        g.push_back(mk(DIST_WIDTH'(495), 2, 5));
        send_group(g, 32'd1, 0);
        idle();
        wait_drain();
    endtask

    task automatic test_saturation();
        cand_t g[$];
        logic [DIST_WIDTH-1:0] ones;
        ones = '1;
        g.push_back(mk(ones, 9, 10));
        send_group(g, 32'd4, 0);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back_wrap();
        cand_t g[$];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            g.delete();
            g.push_back(mk(DIST_WIDTH'(100 * (i + 1)), 10 + i, i + 1));
            send_group(g, 32'd2, 0);
        end
        idle();
        wait_drain();
    endtask

    task automatic test_bubbles();
        test1_group(2);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_reset_mid_group();
        test_tie();
        test_saturation();
        test_back_to_back_wrap();
        test_bubbles();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
